// File: rtl/swipt_pkg.sv
// Shared constants and types for the SWIPT bridge parameter controller.
package swipt_pkg;

  localparam int unsigned FREQ_W = 20;
  localparam int unsigned DUTY_W = 12;

  localparam logic [FREQ_W-1:0] FREQ_MIN  = FREQ_W'(20000);
  localparam logic [FREQ_W-1:0] FREQ_MAX  = FREQ_W'(500000);
  localparam logic [FREQ_W-1:0] FREQ_STEP = FREQ_W'(1000);
  localparam logic [FREQ_W-1:0] FREQ_DEF  = FREQ_W'(100000);

  localparam logic [DUTY_W-1:0] DUTY_MAX      = DUTY_W'(480);
  localparam logic [DUTY_W-1:0] DUTY_DEF      = DUTY_W'(480);
  localparam logic [DUTY_W-1:0] DUTY_ZERO_DEF = DUTY_W'(20);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_RAMP      = 3'd2,
    ST_WAIT_EDGE = 3'd3,
    ST_APPLY     = 3'd4
  } state_e;

  typedef enum logic {
    GNT_TRK = 1'b0,
    GNT_DAT = 1'b1
  } grant_e;

endpackage

// File: rtl/swipt_freq_stepper.sv
// Combinational frequency stepper: moves current toward target by at most step.
module swipt_freq_stepper
  import swipt_pkg::*;
(
  input  logic [FREQ_W-1:0] cur,
  input  logic [FREQ_W-1:0] tgt,
  input  logic [FREQ_W-1:0] step,
  output logic [FREQ_W-1:0] next_c,
  output logic              done_c
);

  logic [FREQ_W-1:0] diff;

  // Clamp the step to the remaining distance so the target is never overshot.
  always_comb begin
    diff   = '0;
    next_c = cur;
    done_c = (cur == tgt);
    if (tgt > cur) begin
      diff   = tgt - cur;
      next_c = cur + ((diff < step) ? diff : step);
    end else if (cur > tgt) begin
      diff   = cur - tgt;
      next_c = cur - ((diff < step) ? diff : step);
    end
  end

endmodule

// File: rtl/swipt_param_ctrl.sv
// Arbitrates tracker/data-modulator requests and applies frequency/duty
// updates to the H-bridge generator only on switching-period boundaries.
module swipt_param_ctrl
  import swipt_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              period_end,
  input  logic              trk_req,
  input  logic [FREQ_W-1:0] trk_freq,
  input  logic [DUTY_W-1:0] trk_duty,
  output logic              trk_ack,
  input  logic              dat_req,
  input  logic [DUTY_W-1:0] dat_duty,
  output logic              dat_ack,
  output logic              rej,
  output logic [FREQ_W-1:0] freq_out,
  output logic [DUTY_W-1:0] duty_out,
  output logic              bridge_nrst,
  output logic              busy
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] duty_req_q, duty_req_d;
  logic              trk_ack_q, trk_ack_d;
  logic              dat_ack_q, dat_ack_d;
  logic              rej_q, rej_d;
  logic              busy_q, busy_d;
  logic              en_s_q, en_s_d;
  logic              bridge_nrst_q, bridge_nrst_d;

  logic              trk_pend;
  logic              dat_pend;
  logic              trk_ok;
  logic              dat_ok;
  logic [FREQ_W-1:0] step_next;
  logic              step_done;

  swipt_freq_stepper u_stepper (
    .cur    (freq_q),
    .tgt    (target_q),
    .step   (FREQ_STEP),
    .next_c (step_next),
    .done_c (step_done)
  );

  // A request still high in its own ack cycle is already served.
  assign trk_pend = trk_req && !trk_ack_q;
  assign dat_pend = dat_req && !dat_ack_q;
  assign trk_ok   = (trk_freq >= FREQ_MIN) && (trk_freq <= FREQ_MAX) && (trk_duty <= DUTY_MAX);
  assign dat_ok   = (dat_duty <= DUTY_MAX);

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_TRK;
      freq_q        <= FREQ_DEF;
      target_q      <= FREQ_DEF;
      duty_q        <= DUTY_DEF;
      duty_req_q    <= DUTY_DEF;
      trk_ack_q     <= 1'b0;
      dat_ack_q     <= 1'b0;
      rej_q         <= 1'b0;
      busy_q        <= 1'b0;
      en_s_q        <= 1'b0;
      bridge_nrst_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      freq_q        <= freq_d;
      target_q      <= target_d;
      duty_q        <= duty_d;
      duty_req_q    <= duty_req_d;
      trk_ack_q     <= trk_ack_d;
      dat_ack_q     <= dat_ack_d;
      rej_q         <= rej_d;
      busy_q        <= busy_d;
      en_s_q        <= en_s_d;
      bridge_nrst_q <= bridge_nrst_d;
    end
  end

  // Next-state, arbitration, ramping and ack generation.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    freq_d        = freq_q;
    target_d      = target_q;
    duty_d        = duty_q;
    duty_req_d    = duty_req_q;
    trk_ack_d     = 1'b0;
    dat_ack_d     = 1'b0;
    rej_d         = 1'b0;
    en_s_d        = enable;
    bridge_nrst_d = enable && en_s_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          trk_ack_d = trk_pend;
          dat_ack_d = dat_pend;
          rej_d     = trk_pend || dat_pend;
        end else if (trk_pend || dat_pend) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        if (!enable || !(trk_pend || dat_pend)) begin
          state_d = ST_IDLE;
        end else if (trk_pend && (!dat_pend || (last_grant_q == GNT_DAT))) begin
          last_grant_d = GNT_TRK;
          if (trk_ok) begin
            target_d   = trk_freq;
            duty_req_d = trk_duty;
            state_d    = ST_RAMP;
          end else begin
            trk_ack_d = 1'b1;
            rej_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          last_grant_d = GNT_DAT;
          if (dat_ok) begin
            duty_req_d = dat_duty;
            state_d    = ST_WAIT_EDGE;
          end else begin
            dat_ack_d = 1'b1;
            rej_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_RAMP: begin
        if (!enable) begin
          trk_ack_d = (last_grant_q == GNT_TRK);
          dat_ack_d = (last_grant_q == GNT_DAT);
          rej_d     = 1'b1;
          state_d   = ST_IDLE;
        end else if (step_done) begin
          state_d = ST_WAIT_EDGE;
        end else if (period_end) begin
          freq_d = step_next;
          if (step_next == target_q) begin
            state_d = ST_WAIT_EDGE;
          end
        end
      end

      ST_WAIT_EDGE: begin
        if (!enable) begin
          trk_ack_d = (last_grant_q == GNT_TRK);
          dat_ack_d = (last_grant_q == GNT_DAT);
          rej_d     = 1'b1;
          state_d   = ST_IDLE;
        end else if (period_end) begin
          duty_d  = (duty_req_q == '0) ? DUTY_ZERO_DEF : duty_req_q;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        trk_ack_d = (last_grant_q == GNT_TRK);
        dat_ack_d = (last_grant_q == GNT_DAT);
        rej_d     = !enable;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign trk_ack     = trk_ack_q;
  assign dat_ack     = dat_ack_q;
  assign rej         = rej_q;
  assign freq_out    = freq_q;
  assign duty_out    = duty_q;
  assign bridge_nrst = bridge_nrst_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_swipt_param_ctrl.sv
// Self-checking bench for swipt_param_ctrl: vector table plus directed sequences,
// with a scoreboard of expected acks checked by a monitor.
module tb_swipt_param_ctrl;
  import swipt_pkg::*;

  logic        clk;
  logic        nrst;
  logic        enable;
  logic        period_end;
  logic        trk_req;
  logic [19:0] trk_freq;
  logic [11:0] trk_duty;
  logic        trk_ack;
  logic        dat_req;
  logic [11:0] dat_duty;
  logic        dat_ack;
  logic        rej;
  logic [19:0] freq_out;
  logic [11:0] duty_out;
  logic        bridge_nrst;
  logic        busy;

  logic pe_auto;
  logic pe_gen;
  logic pe_manual;
  int   pe_cnt;

  int tests;
  int fails;

  typedef struct {
    logic        is_trk;
    logic        rej;
    logic [19:0] freq;
    logic [11:0] duty;
  } exp_t;

  typedef struct {
    logic        is_trk;
    logic [19:0] freq;
    logic [11:0] duty;
    logic        rej;
    logic [19:0] exp_freq;
    logic [11:0] exp_duty;
  } vec_t;

  exp_t sb_q[$];

  swipt_param_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .period_end  (period_end),
    .trk_req     (trk_req),
    .trk_freq    (trk_freq),
    .trk_duty    (trk_duty),
    .trk_ack     (trk_ack),
    .dat_req     (dat_req),
    .dat_duty    (dat_duty),
    .dat_ack     (dat_ack),
    .rej         (rej),
    .freq_out    (freq_out),
    .duty_out    (duty_out),
    .bridge_nrst (bridge_nrst),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign period_end = pe_auto ? pe_gen : pe_manual;

  // Free-running period boundary: one pulse every six cycles.
  initial begin
    pe_gen = 1'b0;
    pe_cnt = 0;
    forever begin
      @(negedge clk);
      pe_cnt = (pe_cnt == 5) ? 0 : pe_cnt + 1;
      pe_gen = (pe_cnt == 0);
    end
  end

  // Every ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (trk_ack || dat_ack) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: trk_ack=%0b dat_ack=%0b rej=%0b freq=%0d duty=%0d, none expected",
                 trk_ack, dat_ack, rej, freq_out, duty_out);
      end else begin
        e = sb_q.pop_front();
        if (trk_ack !== e.is_trk || dat_ack !== !e.is_trk || rej !== e.rej ||
            freq_out !== e.freq || duty_out !== e.duty) begin
          fails++;
          $display("FAIL ack_record: got trk=%0b dat=%0b rej=%0b freq=%0d duty=%0d, expected trk=%0b dat=%0b rej=%0b freq=%0d duty=%0d",
                   trk_ack, dat_ack, rej, freq_out, duty_out,
                   e.is_trk, !e.is_trk, e.rej, e.freq, e.duty);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pe();
    pe_manual = 1'b1;
    @(negedge clk);
    pe_manual = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = 0;
    while (!(trk_ack || dat_ack) && lat < budget) begin
      step(1);
      lat++;
    end
    chk("ack_within_budget", 32'(trk_ack || dat_ack), 32'd1);
  endtask

  task automatic push_exp(input logic is_trk, input logic r, input logic [19:0] f, input logic [11:0] d);
    exp_t e;
    e.is_trk = is_trk;
    e.rej    = r;
    e.freq   = f;
    e.duty   = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    nrst      = 1'b0;
    enable    = 1'b0;
    trk_req   = 1'b0;
    dat_req   = 1'b0;
    pe_manual = 1'b0;
    pe_auto   = 1'b0;
    step(2);
    chk("rst_freq", 32'(freq_out), 32'd100000);
    chk("rst_duty", 32'(duty_out), 32'd480);
    chk("rst_bridge_nrst", 32'(bridge_nrst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({trk_ack, dat_ack, rej}), 32'd0);
    nrst   = 1'b1;
    enable = 1'b1;
    step(1);
    chk("bridge_nrst_1cyc", 32'(bridge_nrst), 32'd0);
    step(1);
    chk("bridge_nrst_2cyc", 32'(bridge_nrst), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  vec_t        vec [10];
  logic [19:0] ramp_exp [4];
  int          lat;
  int          ack_seen;

  initial begin
    tests    = 0;
    fails    = 0;
    trk_freq = '0;
    trk_duty = '0;
    dat_duty = '0;

    vec[0] = '{1'b1, 20'd103500, 12'd300, 1'b0, 20'd103500, 12'd300};
    vec[1] = '{1'b0, 20'd0,      12'd0,   1'b0, 20'd103500, 12'd20};
    vec[2] = '{1'b1, 20'd600000, 12'd100, 1'b1, 20'd103500, 12'd20};
    vec[3] = '{1'b1, 20'd19999,  12'd100, 1'b1, 20'd103500, 12'd20};
    vec[4] = '{1'b1, 20'd500000, 12'd481, 1'b1, 20'd103500, 12'd20};
    vec[5] = '{1'b0, 20'd0,      12'd481, 1'b1, 20'd103500, 12'd20};
    vec[6] = '{1'b1, 20'd20000,  12'd480, 1'b0, 20'd20000,  12'd480};
    vec[7] = '{1'b1, 20'd20000,  12'd0,   1'b0, 20'd20000,  12'd20};
    vec[8] = '{1'b0, 20'd0,      12'd480, 1'b0, 20'd20000,  12'd480};
    vec[9] = '{1'b1, 20'd22500,  12'd100, 1'b0, 20'd22500,  12'd100};

    ramp_exp[0] = 20'd101000;
    ramp_exp[1] = 20'd102000;
    ramp_exp[2] = 20'd103000;
    ramp_exp[3] = 20'd103500;

    // Reset defaults and bridge release timing.
    do_reset();

    // Tracker ramp stepping, one step per period boundary.
    push_exp(1'b1, 1'b0, 20'd103500, 12'd300);
    trk_freq = 20'd103500;
    trk_duty = 12'd300;
    trk_req  = 1'b1;
    step(4);
    chk("ramp_start_freq", 32'(freq_out), 32'd100000);
    chk("ramp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pulse_pe();
      chk("ramp_step_freq", 32'(freq_out), 32'(ramp_exp[i]));
      step(2);
      chk("ramp_hold_freq", 32'(freq_out), 32'(ramp_exp[i]));
    end
    chk("ramp_duty_before_edge", 32'(duty_out), 32'd480);
    pulse_pe();
    chk("ramp_duty_applied", 32'(duty_out), 32'd300);
    chk("ramp_ack_not_yet", 32'(trk_ack), 32'd0);
    step(1);
    chk("ramp_trk_ack", 32'(trk_ack), 32'd1);
    chk("ramp_rej", 32'(rej), 32'd0);
    trk_req = 1'b0;
    step(2);

    // Data request with zero duty and its period-relative latency.
    push_exp(1'b0, 1'b0, 20'd103500, 12'd20);
    dat_duty = 12'd0;
    dat_req  = 1'b1;
    step(3);
    chk("dat_duty_held", 32'(duty_out), 32'd300);
    pulse_pe();
    chk("dat_zero_duty", 32'(duty_out), 32'd20);
    chk("dat_ack_not_yet", 32'(dat_ack), 32'd0);
    step(1);
    chk("dat_ack", 32'(dat_ack), 32'd1);
    dat_req = 1'b0;
    step(2);

    // Out-of-range tracker request: reject two cycles after req.
    push_exp(1'b1, 1'b1, 20'd103500, 12'd20);
    trk_freq = 20'd600000;
    trk_duty = 12'd100;
    trk_req  = 1'b1;
    wait_ack(10, lat);
    chk("reject_latency", 32'(lat), 32'd2);
    chk("reject_freq_held", 32'(freq_out), 32'd103500);
    trk_req = 1'b0;
    step(2);

    // Edge in the grant cycle is ignored; then abort mid-ramp.
    do_reset();
    push_exp(1'b1, 1'b1, 20'd102000, 12'd480);
    trk_freq = 20'd105000;
    trk_duty = 12'd300;
    trk_req  = 1'b1;
    step(1);
    pulse_pe();
    chk("arb_edge_ignored", 32'(freq_out), 32'd100000);
    step(1);
    chk("arb_edge_still", 32'(freq_out), 32'd100000);
    pulse_pe();
    chk("abort_ramp1", 32'(freq_out), 32'd101000);
    step(2);
    pulse_pe();
    chk("abort_ramp2", 32'(freq_out), 32'd102000);
    enable = 1'b0;
    step(1);
    chk("abort_trk_ack", 32'(trk_ack), 32'd1);
    chk("abort_rej", 32'(rej), 32'd1);
    chk("abort_bridge_nrst", 32'(bridge_nrst), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    trk_req = 1'b0;
    pulse_pe();
    pulse_pe();
    chk("abort_freq_hold", 32'(freq_out), 32'd102000);
    chk("abort_duty_hold", 32'(duty_out), 32'd480);

    // Disabled: requests are rejected one cycle after sampling.
    push_exp(1'b0, 1'b1, 20'd102000, 12'd480);
    dat_duty = 12'd100;
    dat_req  = 1'b1;
    step(1);
    chk("disabled_dat_ack", 32'(dat_ack), 32'd1);
    chk("disabled_rej", 32'(rej), 32'd1);
    dat_req = 1'b0;
    step(2);

    // Reset mid-ramp discards the operation without an ack.
    enable = 1'b1;
    step(2);
    chk("reenable_bridge", 32'(bridge_nrst), 32'd1);
    trk_freq = 20'd110000;
    trk_duty = 12'd200;
    trk_req  = 1'b1;
    step(3);
    pulse_pe();
    chk("pre_reset_ramp", 32'(freq_out), 32'd103000);
    nrst    = 1'b0;
    trk_req = 1'b0;
    step(1);
    chk("midramp_rst_freq", 32'(freq_out), 32'd100000);
    chk("midramp_rst_busy", 32'(busy), 32'd0);
    nrst     = 1'b1;
    pe_auto  = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (trk_ack || dat_ack) ack_seen++;
    end
    chk("no_ack_after_reset", 32'(ack_seen), 32'd0);
    chk("midramp_freq_stays", 32'(freq_out), 32'd100000);

    // Collision arbitration: data first after reset, then alternate.
    do_reset();
    pe_auto = 1'b1;
    push_exp(1'b0, 1'b0, 20'd100000, 12'd200);
    push_exp(1'b1, 1'b0, 20'd101500, 12'd250);
    push_exp(1'b0, 1'b0, 20'd101500, 12'd150);
    trk_freq = 20'd101500;
    trk_duty = 12'd250;
    dat_duty = 12'd200;
    trk_req  = 1'b1;
    dat_req  = 1'b1;
    wait_ack(200, lat);
    chk("collide1_dat_first", 32'(dat_ack), 32'd1);
    dat_req = 1'b0;
    step(1);
    dat_duty = 12'd150;
    dat_req  = 1'b1;
    wait_ack(200, lat);
    chk("collide2_trk_wins", 32'(trk_ack), 32'd1);
    trk_req = 1'b0;
    step(1);
    wait_ack(200, lat);
    chk("collide3_dat_served", 32'(dat_ack), 32'd1);
    dat_req = 1'b0;
    step(2);

    // Table of single requests, chained through the applied state.
    do_reset();
    pe_auto = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_exp(vec[i].is_trk, vec[i].rej, vec[i].exp_freq, vec[i].exp_duty);
      if (vec[i].is_trk) begin
        trk_freq = vec[i].freq;
        trk_duty = vec[i].duty;
        trk_req  = 1'b1;
      end else begin
        dat_duty = vec[i].duty;
        dat_req  = 1'b1;
      end
      wait_ack(3000, lat);
      trk_req = 1'b0;
      dat_req = 1'b0;
      step(2);
    end

    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
